// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter fed by a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmit #(
  parameter int CLK_FREQ = 49_996_800,
  parameter int BAUD     = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       finished_send
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIVISOR - 1);
  // stop ends one cycle early so the registered ready lines up with the bit end
  localparam logic [CW-1:0] STOP_CNT = CW'(DIVISOR - 2);

  if (DIVISOR < 2) begin : g_div_check
    $error("uart_transmit: CLK_FREQ / BAUD must be at least 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ready;
  logic          r_done;

  state_t        w_state_nx;
  logic [CW-1:0] w_baud_nx;
  logic [2:0]    w_bit_nx;
  logic [7:0]    w_shift_nx;
  logic          w_tx_nx;
  logic          w_ready_nx;
  logic          w_done_nx;
  logic          w_bit_end;
  logic          w_accept;

  assign w_bit_end = (r_baud == LAST_CNT);
  assign w_accept  = send && r_ready;

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_parity <= ^dataIn;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
      r_ready <= w_ready_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + 1'b1;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_ready_nx = 1'b0;
    w_done_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
        w_ready_nx = 1'b1;
        if (w_accept) begin
          w_state_nx = S_START;
          w_shift_nx = dataIn;
          w_bit_nx   = '0;
          w_tx_nx    = 1'b0;
          w_ready_nx = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nx = S_DATA;
          w_baud_nx  = '0;
          w_tx_nx    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nx  = '0;
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nx = S_PARITY;
            w_tx_nx    = r_parity;
`else
            w_state_nx = S_STOP;
            w_tx_nx    = 1'b1;
`endif
          end else begin
            w_tx_nx = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nx = S_STOP;
          w_baud_nx  = '0;
          w_tx_nx    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_tx_nx = 1'b1;
        if (r_baud == STOP_CNT) begin
          w_state_nx = S_IDLE;
          w_baud_nx  = '0;
          w_ready_nx = 1'b1;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

  assign tx            = r_tx;
  assign ready         = r_ready;
  assign finished_send = r_done;

endmodule

// File: doc/uart_transmit.md
# uart_transmit

Serial UART transmitter: accepts one byte over a valid/ready handshake and drives it onto the `tx` line as a standard 8N1 frame: start bit, 8 data bits LSB first, stop bit. It is the upstream partner of `uart_receive`, so the two connect `tx` → `rx` for loopback. Bit timing is derived from the system clock by an integer divisor, identical to the receiver's.

## Interface

Parameters:
- `CLK_FREQ`, default 49_996_800: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived `DIVISOR = CLK_FREQ / BAUD` (integer truncation; 5208 at defaults).
  - Must be ≥ 2; elaboration fails otherwise.

Ports:
- `clock`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `dataIn`, in, 8: byte to transmit; sampled only on acceptance.
- `send`, in, 1: request valid.
- `ready`, out, 1: transmitter idle and able to accept.
- `tx`, out, 1: serial line; idles high.
- `finished_send`, out, 1: one-cycle pulse at the end of each frame.

## Operation

- States: IDLE, START, DATA, (PARITY, only when `UART_TX_PARITY_EN` is defined), STOP.
- Acceptance occurs at a rising edge with `send && ready`.
  - `dataIn` is latched into a shift register.
  - The state moves IDLE → START.
  - `ready` deasserts.
  - Later changes on `dataIn` and `send` have no effect until the next acceptance.
- The baud counter runs from 0 to DIVISOR-1 and wraps. It is reset to 0 on acceptance and on every state change.
- Each line bit is held for exactly DIVISOR cycles.
- START: `tx`=0, lasts one bit period, then DATA.
- DATA: `tx` = shift register bit 0.
  - At each bit-period end, the register shifts right and the 3-bit bit counter increments.
  - After bit 7 (counter wraps 7→0) the state moves to PARITY or STOP.
- STOP: `tx`=1 for one bit period. At its last cycle, `finished_send` pulses and the state returns to IDLE.
- `tx`, `ready` and `finished_send` are registered outputs with no combinational path from inputs.
- `send` asserted while `ready`=0 is ignored and is not queued.
- Boundary conditions:
  - **Back-to-back:** if `send` is high in the cycle `ready` returns high, that edge accepts the next byte. The stop bit is then followed directly by the next start bit, with no extra idle cycles.
  - **Reset mid-frame:** `tx` goes high and `ready` goes high immediately (asynchronously). The frame is abandoned, and no `finished_send` pulse is produced.
  - **Reset values:** `tx`=1, `ready`=1, `finished_send`=0, state IDLE, all counters 0, shift register 0.

## Timing

- Take edge 0 as the acceptance edge.
- After edge 0, `tx`=0 and `ready`=0.
- Start bit: `tx` low for edges 0 … DIVISOR-1.
- Data bit k (k = 0…7) occupies edges (k+1)·DIVISOR … (k+2)·DIVISOR-1.
- Stop bit occupies 9·DIVISOR … 10·DIVISOR-1.
- After edge 10·DIVISOR-1: `ready`=1 and `finished_send`=1 for exactly one cycle.
- Frame length is 10·DIVISOR cycles, or 11·DIVISOR with parity.
- Minimum back-to-back period equals the frame length.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 latched data bits (even parity) for one bit period.
  - Frame is 11·DIVISOR cycles.
- Undefined: no parity state; 8N1 framing; 10·DIVISOR-cycle frame.

## Test plan

- **Reset:** assert `reset` for 2 cycles → `tx`=1, `ready`=1, `finished_send`=0; deassert → outputs unchanged, no activity.
- **Single frame:** `dataIn`=0x0F, `send` for 1 cycle at defaults.
  - `tx` low for 5208 cycles, then 1,1,1,1,0,0,0,0 at 5208 cycles each, then high for 5208 cycles.
  - `finished_send` pulses once at cycle 52079 after acceptance; `ready` high from then on.
  - Loopback into `uart_receive` yields `dataOut`=0x0F.
- **Handshake:** change `dataIn` to 0xA5 and toggle `send` mid-frame → transmitted byte stays 0x0F; no second frame starts.
- **Back-to-back:** `send` held high with 0x55 then 0xAA.
  - Second start bit begins on the cycle immediately after the first stop bit ends.
  - Exactly two `finished_send` pulses, 52080 cycles apart.
- **Reset mid-frame:** assert `reset` during data bit 3 → `tx`=1 and `ready`=1 immediately, no `finished_send` pulse; next `send` produces a complete, correct frame.
- **Parity build:** `UART_TX_PARITY_EN` defined, `dataIn`=0x07 → parity bit 1 at cycles 46872…52079, stop bit follows, frame 57288 cycles.
